// File: rtl/cut_gen_pkg.sv
// Shared constants, state encoding and single-step LFSR helper for the
// cut-position keystream generator (also reused by the descrambler side).
package cut_gen_pkg;

  localparam int unsigned LFSR_WIDTH      = 32;
  localparam logic [LFSR_WIDTH-1:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [LFSR_WIDTH-1:0] LFSR_ONE  = 32'h0000_0001;
  localparam int unsigned CUT_WIDTH       = 8;
  localparam int unsigned FRAME_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_RUN        = 2'd2
  } cut_state_t;

  // One Galois step: shift right, fold the mask back in when bit 0 falls out.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
    logic [LFSR_WIDTH-1:0] fb;
    fb = s[0] ? LFSR_MASK : {LFSR_WIDTH{1'b0}};
    return {1'b0, s[LFSR_WIDTH-1:1]} ^ fb;
  endfunction

endpackage

// File: rtl/lfsr32_step8.sv
// Combinational advance of the 32-bit Galois LFSR by eight steps.
module lfsr32_step8
  import cut_gen_pkg::*;
(
  input  logic [LFSR_WIDTH-1:0] state_i,
  output logic [LFSR_WIDTH-1:0] state_o
);

  // Unrolled chain of eight single steps.
  always_comb begin
    state_o = state_i;
    for (int i = 0; i < 8; i++) begin
      state_o = lfsr_step(state_o);
    end
  end

endmodule

// File: rtl/cut_position_generator.sv
// Per-line cut position keystream: keyed LFSR reseeded at each field-1 frame
// start and advanced eight steps on every active-line H rise.
module cut_position_generator
  import cut_gen_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       H,
  input  logic                       V,
  input  logic                       F,
  input  logic [LFSR_WIDTH-1:0]      seed_in,
  input  logic                       seed_load,
  output logic [CUT_WIDTH-1:0]       cut_position,
  output logic                       cut_valid,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

  cut_state_t                 state_q;
  logic [LFSR_WIDTH-1:0]      lfsr_q;
  logic [LFSR_WIDTH-1:0]      key_q;
  logic [FRAME_CNT_WIDTH-1:0] frame_count_q;
  logic [CUT_WIDTH-1:0]       cut_q;
  logic                       cut_valid_q;
  logic                       prev_h_q;
  logic                       prev_v_q;

  logic                       h_rise_d;
  logic                       active_h_d;
  logic                       frame_start_d;
  logic [LFSR_WIDTH-1:0]      reseed_d;
  logic [LFSR_WIDTH-1:0]      step_in_d;
  logic [LFSR_WIDTH-1:0]      step_out_d;
  logic [LFSR_WIDTH-1:0]      seed_d;

  // Edge detection, reseed value and the single step8 operand selection.
  always_comb begin
    h_rise_d      = H & ~prev_h_q;
    active_h_d    = h_rise_d & ~V;
    frame_start_d = ~V & prev_v_q & ~F;
    reseed_d      = key_q ^ {{(LFSR_WIDTH-FRAME_CNT_WIDTH){1'b0}}, frame_count_q};
    if (reseed_d == {LFSR_WIDTH{1'b0}}) begin
      reseed_d = LFSR_ONE;
    end else begin
      reseed_d = reseed_d;
    end
    // A coincident frame start steps from the fresh reseed, not the old state.
    step_in_d = frame_start_d ? reseed_d : lfsr_q;
    seed_d    = (seed_in == {LFSR_WIDTH{1'b0}}) ? LFSR_ONE : seed_in;
  end

  lfsr32_step8 u_step8 (
    .state_i (step_in_d),
    .state_o (step_out_d)
  );

  // Control FSM with registered keystream outputs; seed_load overrides all.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      lfsr_q        <= LFSR_ONE;
      key_q         <= {LFSR_WIDTH{1'b0}};
      frame_count_q <= {FRAME_CNT_WIDTH{1'b0}};
      cut_q         <= {CUT_WIDTH{1'b0}};
      cut_valid_q   <= 1'b0;
      prev_h_q      <= 1'b0;
      prev_v_q      <= 1'b0;
    end else begin
      prev_h_q <= H;
      prev_v_q <= V;
      if (seed_load) begin
        key_q         <= seed_d;
        frame_count_q <= {FRAME_CNT_WIDTH{1'b0}};
        cut_q         <= {CUT_WIDTH{1'b0}};
        cut_valid_q   <= 1'b0;
        state_q       <= ST_WAIT_FRAME;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_IDLE;
          end
          ST_WAIT_FRAME, ST_RUN: begin
            if (frame_start_d) begin
              frame_count_q <= frame_count_q + FRAME_CNT_WIDTH'(1);
              state_q       <= ST_RUN;
              cut_valid_q   <= 1'b1;
              if (active_h_d) begin
                lfsr_q <= step_out_d;
                cut_q  <= step_out_d[CUT_WIDTH-1:0];
              end else begin
                lfsr_q <= reseed_d;
              end
            end else if ((state_q == ST_RUN) && active_h_d) begin
              lfsr_q <= step_out_d;
              cut_q  <= step_out_d[CUT_WIDTH-1:0];
            end else begin
              lfsr_q <= lfsr_q;
            end
          end
          default: begin
            state_q     <= ST_IDLE;
            cut_q       <= {CUT_WIDTH{1'b0}};
            cut_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cut_position = cut_q;
  assign cut_valid    = cut_valid_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_cut_position_generator.sv
// Self-checking bench for cut_position_generator: a cycle reference model
// pushes expected outputs into a scoreboard queue at each drive, and they are
// popped and compared just after the following rising edge.
module tb_cut_position_generator;

  logic        clk;
  logic        reset_n;
  logic        H, V, F;
  logic [31:0] seed_in;
  logic        seed_load;
  logic [7:0]  cut_position;
  logic        cut_valid;
  logic [15:0] frame_count;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0]  cut;
    logic        valid;
    logic [15:0] fc;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state
  int          m_st;    // 0 idle, 1 wait, 2 run
  logic [31:0] m_lfsr, m_key;
  logic [15:0] m_fc;
  logic [7:0]  m_cut;
  logic        m_ph, m_pv;

  cut_position_generator dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .H            (H),
    .V            (V),
    .F            (F),
    .seed_in      (seed_in),
    .seed_load    (seed_load),
    .cut_position (cut_position),
    .cut_valid    (cut_valid),
    .frame_count  (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_step8(input logic [31:0] s);
    logic [31:0] r;
    logic        lsb;
    r = s;
    for (int k = 0; k < 8; k++) begin
      lsb = r[0];
      r   = r >> 1;
      if (lsb) r = r ^ 32'h8020_0003;
    end
    return r;
  endfunction

  // Drive one cycle, advance the model, then compare after the edge.
  task automatic step(input logic rn, input logic h, input logic v, input logic f,
                      input logic sl, input logic [31:0] seed);
    logic hr, fs;
    logic [31:0] rs;
    exp_t e, got;
    @(negedge clk);
    reset_n = rn; H = h; V = v; F = f; seed_load = sl; seed_in = seed;
    if (!rn) begin
      m_st = 0; m_lfsr = 32'h1; m_key = 32'h0; m_fc = 16'h0; m_cut = 8'h0;
      m_ph = 1'b0; m_pv = 1'b0;
    end else begin
      hr = h & !m_ph;
      fs = !v & m_pv & !f;
      m_ph = h; m_pv = v;
      if (sl) begin
        m_key = (seed == 32'h0) ? 32'h1 : seed;
        m_fc = 16'h0; m_cut = 8'h0; m_st = 1;
      end else if (m_st != 0 && fs) begin
        rs = m_key ^ {16'h0, m_fc};
        if (rs == 32'h0) rs = 32'h1;
        if (hr && !v) begin
          rs = ref_step8(rs);
          m_cut = rs[7:0];
        end
        m_lfsr = rs;
        m_fc = m_fc + 16'h1;
        m_st = 2;
      end else if (m_st == 2 && hr && !v) begin
        m_lfsr = ref_step8(m_lfsr);
        m_cut = m_lfsr[7:0];
      end
    end
    e.cut = m_cut; e.valid = (m_st == 2); e.fc = m_fc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got.cut = cut_position; got.valid = cut_valid; got.fc = frame_count;
    e = sb_q.pop_front();
    checks++;
    if (got.cut !== e.cut) begin
      errors++;
      $display("FAIL sb_cut t=%0t: got %h expected %h", $time, got.cut, e.cut);
    end
    checks++;
    if (got.valid !== e.valid) begin
      errors++;
      $display("FAIL sb_valid t=%0t: got %b expected %b", $time, got.valid, e.valid);
    end
    checks++;
    if (got.fc !== e.fc) begin
      errors++;
      $display("FAIL sb_fc t=%0t: got %h expected %h", $time, got.fc, e.fc);
    end
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_0000);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1234_0000);
    checks++;
    if (dut.lfsr_q !== 32'h0000_0001) begin
      errors++;
      $display("FAIL reset_lfsr: got %h expected %h", dut.lfsr_q, 32'h0000_0001);
    end
  endtask

  task automatic test_no_key();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, i[1], i[3], i[4], 1'b0, 32'h0);
    end
    checks++;
    if ({cut_position, cut_valid, frame_count} !== 25'h0) begin
      errors++;
      $display("FAIL no_key_idle: got %h expected %h", {cut_position, cut_valid, frame_count}, 25'h0);
    end
  endtask

  task automatic test_zero_seed();
    logic [31:0] s8;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);   // frame start
    checks++;
    if (dut.lfsr_q !== 32'h1 || frame_count !== 16'd1 || cut_valid !== 1'b1) begin
      errors++;
      $display("FAIL zero_seed_start: got lfsr=%h fc=%0d valid=%b expected lfsr=1 fc=1 valid=1",
               dut.lfsr_q, frame_count, cut_valid);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);   // first active H rise
    s8 = ref_step8(32'h1);
    checks++;
    if (cut_position !== s8[7:0]) begin
      errors++;
      $display("FAIL zero_seed_first_cut: got %h expected %h", cut_position, s8[7:0]);
    end
  endtask

  // Two 525-line frames with shortened lines (32 samples, H high for 8).
  task automatic test_frames();
    logic v, f;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
    for (int fr = 0; fr < 2; fr++) begin
      for (int ln = 0; ln < 525; ln++) begin
        v = (ln < 20) || (ln >= 262 && ln < 282);
        f = (ln >= 262);
        for (int smp = 0; smp < 32; smp++) begin
          step(1'b1, (smp < 8), v, f, 1'b0, 32'h0);
        end
      end
    end
    checks++;
    if (frame_count !== 16'd2) begin
      errors++;
      $display("FAIL frames_count: got %0d expected %0d", frame_count, 2);
    end
  endtask

  task automatic test_coincident();
    logic [31:0] s8;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);   // V fall + H rise together
    s8 = ref_step8(32'h1234_5678);
    checks++;
    if (cut_position !== s8[7:0] || dut.lfsr_q !== s8) begin
      errors++;
      $display("FAIL coincident: got cut=%h lfsr=%h expected cut=%h lfsr=%h",
               cut_position, dut.lfsr_q, s8[7:0], s8);
    end
  endtask

  task automatic test_reload_mid_run();
    for (int i = 0; i < 12; i++) step(1'b1, i[1], 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);
    checks++;
    if (cut_position !== 8'h0 || cut_valid !== 1'b0 || frame_count !== 16'h0) begin
      errors++;
      $display("FAIL reload: got cut=%h valid=%b fc=%h expected 0 0 0",
               cut_position, cut_valid, frame_count);
    end
    for (int i = 0; i < 8; i++) step(1'b1, i[1], 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);   // field-2 V fall: no start
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);   // field-1 frame start
    checks++;
    if (cut_valid !== 1'b1 || dut.lfsr_q !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL reload_resume: got valid=%b lfsr=%h expected 1 %h",
               cut_valid, dut.lfsr_q, 32'hCAFE_F00D);
    end
    for (int i = 0; i < 8; i++) step(1'b1, i[1], 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    force dut.frame_count_q = 16'hFFFF;
    #1;
    release dut.frame_count_q;
    m_fc = 16'hFFFF;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);   // frame start with count FFFF
    checks++;
    if (frame_count !== 16'h0 || dut.lfsr_q !== (32'hCAFE_F00D ^ 32'h0000_FFFF)) begin
      errors++;
      $display("FAIL wrap: got fc=%h lfsr=%h expected fc=0000 lfsr=%h",
               frame_count, dut.lfsr_q, 32'hCAFE_F00D ^ 32'h0000_FFFF);
    end
    for (int i = 0; i < 8; i++) step(1'b1, i[1], 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset_mid_run();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h5555_AAAA);
    checks++;
    if (cut_valid !== 1'b0 || cut_position !== 8'h0 || dut.key_q !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b cut=%h key=%h expected 0 00 0",
               cut_valid, cut_position, dut.key_q);
    end
    for (int i = 0; i < 16; i++) step(1'b1, i[1], i[2], 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; H = 1'b0; V = 1'b0; F = 1'b0; seed_in = 32'h0; seed_load = 1'b0;
    m_st = 0; m_lfsr = 32'h1; m_key = 32'h0; m_fc = 16'h0; m_cut = 8'h0;
    m_ph = 1'b0; m_pv = 1'b0;
    test_reset();
    test_no_key();
    test_zero_seed();
    test_frames();
    test_coincident();
    test_reload_mid_run();
    test_wrap();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
